// File: rtl/reg_file_dump_if.sv
// Beat stream carrying one (index, data) register snapshot per valid/ready handshake.
// A beat transfers on a rising clk edge where out_valid && out_ready; the producer holds index/data/last stable until then.
interface reg_file_dump_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_index;
  logic [DATA_W-1:0] out_data;
  logic              out_last;

  modport master (
    output out_valid,
    output out_index,
    output out_data,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_index,
    input  out_data,
    input  out_last,
    output out_ready
  );
endinterface

// File: rtl/reg_file_dump.sv
// Walks register indices 0..NUM_REGS-1 through one register-file read port and
// streams each snapshot as an (index, data) beat; one dump per start request.
module reg_file_dump #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  reg_file_dump_if.master   dump,
  output logic              busy,
  output logic              done,
  output logic [1:0]        state_dbg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_READ = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

  logic [1:0]        state, state_nx;
  logic [ADDR_W-1:0] idx, idx_nx;
  logic [ADDR_W-1:0] snap_index;
  logic [DATA_W-1:0] snap_data;
  logic              beat_xfer;

  assign beat_xfer = (state == S_HOLD) && dump.out_ready;

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    case (state)
      S_IDLE: begin
        idx_nx = '0;
        if (start) state_nx = S_READ;
      end
      S_READ: state_nx = S_HOLD;
      S_HOLD: begin
        if (beat_xfer) begin
          if (idx == LAST_IDX) begin
            state_nx = S_DONE;
          end else begin
            idx_nx   = idx + 1'b1;
            state_nx = S_READ;
          end
        end
      end
      // A start arriving during DONE is dropped; only IDLE honours requests.
      S_DONE: begin
        idx_nx   = '0;
        state_nx = S_IDLE;
      end
      default: begin
        idx_nx   = '0;
        state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      idx   <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
    end
  end

  // Snapshot is taken only at the end of READ, so later register-file writes
  // cannot disturb a beat that is waiting in HOLD.
  always_ff @(posedge clk) begin
    if (reset) begin
      snap_index <= '0;
      snap_data  <= '0;
    end else if (state == S_READ) begin
      snap_index <= idx;
      snap_data  <= rd_data;
    end
  end

  assign rd_addr        = idx;
  assign dump.out_valid = (state == S_HOLD);
  assign dump.out_index = snap_index;
  assign dump.out_data  = snap_data;
  assign dump.out_last  = (state == S_HOLD) && (snap_index == LAST_IDX);
  assign busy           = (state != S_IDLE);
  assign done           = (state == S_DONE);
  assign state_dbg      = state;

endmodule

// File: tb/tb_reg_file_dump.sv
// Scoreboarded bench for reg_file_dump: a behavioural register file feeds the read port,
// expected beats are queued at start and popped by a negedge monitor on each handshake.
module tb_reg_file_dump;
  localparam int N  = 32;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int EW = AW + DW + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic start4 = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] rd_addr, rd_addr4;
  logic [DW-1:0] rd_data, rd_data4;
  logic          busy, done, busy4, done4;
  logic [1:0]    state_dbg, state_dbg4;
  logic [DW-1:0] regs [N];

  assign rd_data  = regs[rd_addr];
  assign rd_data4 = regs[rd_addr4];

  reg_file_dump_if #(.ADDR_W(AW), .DATA_W(DW)) sif ();
  reg_file_dump_if #(.ADDR_W(AW), .DATA_W(DW)) sif4 ();

  reg_file_dump #(.NUM_REGS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .reset(reset), .start(start), .rd_addr(rd_addr), .rd_data(rd_data),
    .dump(sif.master), .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  reg_file_dump #(.NUM_REGS(4), .ADDR_W(AW), .DATA_W(DW)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .rd_addr(rd_addr4), .rd_data(rd_data4),
    .dump(sif4.master), .busy(busy4), .done(done4), .state_dbg(state_dbg4)
  );

  logic [EW-1:0] exp_q[$];
  int total = 0;
  int bad = 0;
  int beat_cnt = 0;
  int ready_mode = 0;  // 0: always ready, 1: random, 2: driven by the main sequence

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- ready driver ----------------
  initial begin
    sif.out_ready  = 1'b1;
    sif4.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (ready_mode == 0) sif.out_ready = 1'b1;
      else if (ready_mode == 1) sif.out_ready = 1'($urandom_range(0, 1));
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!reset) begin
      if (done && sif.out_valid) check("done_with_valid", 64'(done && sif.out_valid), 64'd0);
      if (sif.out_valid && sif.out_ready) begin
        logic [EW-1:0] got, exp;
        got = {sif.out_index, sif.out_data, sif.out_last};
        beat_cnt++;
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL beat_unexpected: got=%h expected=none", got);
        end else begin
          exp = exp_q.pop_front();
          check("beat", 64'(got), 64'(exp));
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_all();
    for (int k = 0; k < N; k++)
      exp_q.push_back({AW'(k), regs[k], (k == N - 1)});
  endtask

  // Pulses start for one edge (E0); returns #1 after E0.
  task automatic do_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Cycle 1 is the cycle right after the start edge.
  task automatic wait_done(input int budget, output int cyc);
    cyc = 1;
    while (!done && cyc < budget) begin
      @(posedge clk);
      #1 cyc++;
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got=no_done expected=done within %0d cycles", budget);
    end
  endtask

  task automatic wait_index(input int target);
    int n = 0;
    while (!(sif.out_valid && sif.out_index == AW'(target)) && n < 300) begin
      @(posedge clk);
      #1 n++;
    end
    check("reach_index", 64'(sif.out_valid && sif.out_index == AW'(target)), 64'd1);
  endtask

  task automatic check_idle_zero(input string tag);
    check({tag, "_valid"}, 64'(sif.out_valid), 64'd0);
    check({tag, "_last"},  64'(sif.out_last),  64'd0);
    check({tag, "_busy"},  64'(busy),          64'd0);
    check({tag, "_done"},  64'(done),          64'd0);
    check({tag, "_addr"},  64'(rd_addr),       64'd0);
    check({tag, "_index"}, 64'(sif.out_index), 64'd0);
    check({tag, "_data"},  64'(sif.out_data),  64'd0);
    check({tag, "_state"}, 64'(state_dbg),     64'd0);
  endtask

  task automatic end_of_dump(input string tag);
    check({tag, "_beats"}, 64'(beat_cnt), 64'd32);
    check({tag, "_q_empty"}, 64'(exp_q.size()), 64'd0);
    beat_cnt = 0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cyc;
    int k;
    for (int i = 0; i < N; i++) regs[i] = 32'hA500_0000 + 32'(i);
    repeat (3) @(posedge clk);
    #1;
    check_idle_zero("reset");
    reset = 1'b0;

    // full dump, ready tied high
    ready_mode = 0;
    push_all();
    do_start();
    wait_done(200, cyc);
    check("t1_done_cycle", 64'(cyc), 64'd65);
    @(posedge clk);
    #1 check("t1_busy_after", 64'(busy), 64'd0);
    end_of_dump("t1");

    // stall on beat 16 while register 16 is overwritten
    regs[16] = 32'h0000_000A;
    push_all();
    ready_mode = 2;
    sif.out_ready = 1'b1;
    do_start();
    wait_index(16);
    sif.out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) regs[16] = 32'hFFFF_FFFF;
      check("t2_stall_data",  64'(sif.out_data),  64'h0000_000A);
      check("t2_stall_index", 64'(sif.out_index), 64'd16);
      check("t2_stall_valid", 64'(sif.out_valid), 64'd1);
      @(posedge clk);
      #1;
    end
    sif.out_ready = 1'b1;
    wait_done(200, cyc);
    @(posedge clk);
    #1;
    end_of_dump("t2");

    // random backpressure
    ready_mode = 1;
    push_all();
    do_start();
    wait_done(2000, cyc);
    @(posedge clk);
    #1 check("t3_busy_after", 64'(busy), 64'd0);
    end_of_dump("t3");

    // start held through a whole dump including DONE
    ready_mode = 0;
    push_all();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1;
    wait_done(200, cyc);
    check("t4_done_cycle", 64'(cyc), 64'd65);
    start = 1'b0;
    @(posedge clk);
    #1 check("t4_no_relaunch", 64'(busy), 64'd0);
    @(posedge clk);
    #1 check("t4_still_idle", 64'(busy), 64'd0);
    end_of_dump("t4a");
    push_all();
    do_start();
    check("t4_relaunch", 64'(busy), 64'd1);
    wait_done(200, cyc);
    @(posedge clk);
    #1;
    end_of_dump("t4b");

    // reset while holding beat 7
    ready_mode = 2;
    sif.out_ready = 1'b1;
    push_all();
    do_start();
    wait_index(7);
    sif.out_ready = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    check_idle_zero("midreset");
    check("midreset_beats", 64'(beat_cnt), 64'd7);
    exp_q.delete();
    beat_cnt = 0;
    ready_mode = 0;
    push_all();
    do_start();
    wait_done(200, cyc);
    check("t5_done_cycle", 64'(cyc), 64'd65);
    @(posedge clk);
    #1;
    end_of_dump("t5");

    // four-register build, ready tied high
    @(posedge clk);
    #1 start4 = 1'b1;
    @(posedge clk);
    #1 start4 = 1'b0;
    cyc = 1;
    k = 0;
    while (!done4 && cyc < 50) begin
      if (sif4.out_valid) begin
        check("n4_index", 64'(sif4.out_index), 64'(k));
        check("n4_data",  64'(sif4.out_data),  64'(regs[k]));
        check("n4_last",  64'(sif4.out_last),  64'(k == 3));
        k++;
      end
      @(posedge clk);
      #1 cyc++;
    end
    check("n4_done", 64'(done4), 64'd1);
    check("n4_done_cycle", 64'(cyc), 64'd9);
    check("n4_beats", 64'(k), 64'd4);
    @(posedge clk);
    #1 check("n4_busy_after", 64'(busy4), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout: got=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
